spi_seq_fifo: RTL

Upstream/downstream companion of the SPI master controller. It buffers host TX bytes in a FIFO and launches one controller frame per byte via a single-cycle spi_enable pulse. It holds spi_data_in stable for the whole frame, captures the received byte from the controller's data_out/cs, and pushes it into an RX FIFO. Host side is valid/ready streaming on both directions.

---
 rtl/spi_seq_fifo.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_seq_fifo.sv
// Byte sequencer in front of an SPI master controller: TX FIFO -> one controller frame per byte -> RX FIFO.
// Optional frame watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_seq_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          spi_enable,
  output logic [DATA_WIDTH-1:0]         spi_data_in,
  input  logic                          spi_cs,
  input  logic [DATA_WIDTH-1:0]         spi_data_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          timeout_err,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_WIDE = (CW + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_seq_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1 || GAP_CYCLES < 0) begin : g_bad_timing
    $error("spi_seq_fifo: TIMEOUT_CYCLES must be >= 1 and GAP_CYCLES >= 0");
  end

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid must not depend on ready, and offered data holds until accepted.

  typedef enum logic [1:0] {IDLE, START, ACTIVE, GAP} state_t;

  state_t                  state, state_nxt;
  logic                    tx_push, tx_pop, rx_push, rx_pop;
  logic                    gap_load, abort, start_to, active_to;
  logic                    pending;
  logic                    launch_ok;
  logic [CW:0]             rx_reserved;
  logic [GW-1:0]           gap_cnt;
  logic [DATA_WIDTH-1:0]   rx_hold;

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0]   tx_mem [FIFO_DEPTH];
  logic [AW-1:0]           tx_wr_ptr, tx_rd_ptr;

  assign tx_ready = (tx_count != DEPTH_C);
  assign tx_push  = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0]   rx_mem [FIFO_DEPTH];
  logic [AW-1:0]           rx_wr_ptr, rx_rd_ptr;

  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_hold;
  end

  // ---------------- Frame sequencer ----------------
  // A launch reserves one RX slot so the frame result always has a place to land.
  assign rx_reserved = {1'b0, rx_count} + {{CW{1'b0}}, pending};
  assign launch_ok   = (tx_count != '0) && (rx_reserved < DEPTH_WIDE);

  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    gap_load  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (launch_ok) begin
          tx_pop    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (!spi_cs) begin
          state_nxt = ACTIVE;
        end else if (start_to) begin
          abort     = 1'b1;
          gap_load  = 1'b1;
          state_nxt = GAP;
        end
      end
      ACTIVE: begin
        if (spi_cs) begin
          rx_push   = 1'b1;
          gap_load  = 1'b1;
          state_nxt = GAP;
        end else if (active_to) begin
          abort     = 1'b1;
          gap_load  = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      spi_enable  <= 1'b0;
      spi_data_in <= '0;
      rx_hold     <= '0;
      gap_cnt     <= '0;
      pending     <= 1'b0;
    end else begin
      state      <= state_nxt;
      spi_enable <= tx_pop;
      if (tx_pop) spi_data_in <= tx_mem[tx_rd_ptr];
      // The controller only drives data_out late in the frame; the last cs-low value wins.
      if (state == ACTIVE && !spi_cs) rx_hold <= spi_data_out;
      if (gap_load) begin
        gap_cnt <= GW'(GAP_CYCLES);
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      if (tx_pop) begin
        pending <= 1'b1;
      end else if (rx_push || abort) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TMAX = (TIMEOUT_CYCLES > 16) ? TIMEOUT_CYCLES : 16;
  localparam int TW   = $clog2(TMAX + 1);

  logic [TW-1:0] to_cnt;
  logic          to_err_q;

  // Counter restarts on every state change, so it measures time spent in the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state != state_nxt) begin
        to_cnt <= '0;
      end else if (state == START || state == ACTIVE) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (abort) to_err_q <= 1'b1;
    end
  end

  assign start_to    = (to_cnt == TW'(15));
  assign active_to   = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = to_err_q;
`else
  assign start_to    = 1'b0;
  assign active_to   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign busy      = (state != IDLE) || (tx_count != '0);
  assign dbg_state = state;

endmodule
